// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 decrypt stage: FSM states, byte and
// S-box sizes, and the plaintext character filter used for early key rejection.
package rc4_pkg;

  localparam int BYTE_W = 8;
  localparam int S_SIZE = 256;

  localparam logic [BYTE_W-1:0] CHAR_SPACE = 8'h20;
  localparam logic [BYTE_W-1:0] CHAR_A     = 8'h61;
  localparam logic [BYTE_W-1:0] CHAR_Z     = 8'h7A;

  // One state per clock of the 13-cycle per-byte PRGA sequence, plus IDLE/DONE.
  typedef enum logic [3:0] {
    IDLE,
    INC_I,
    WAIT_SI,
    READ_SI,
    CALC_J,
    WAIT_SJ,
    READ_SJ,
    WRITE_SI,
    WRITE_SJ,
    SET_F,
    WAIT_F,
    READ_F,
    WRITE_D,
    NEXT,
    DONE
  } rc4_state_t;

  // A plaintext byte is acceptable only if it is a space or a lowercase letter.
  function automatic logic is_valid_char(input logic [BYTE_W-1:0] c);
    return (c == CHAR_SPACE) || ((c >= CHAR_A) && (c <= CHAR_Z));
  endfunction

endpackage

// File: rtl/rc4_decrypt.sv
// RC4 pseudo-random generation and decrypt stage. Walks the PRGA loop over
// the S memory left by key scheduling, XORs each keystream byte with the
// encrypted ROM and writes plaintext to the decrypted RAM. Any byte outside
// {space, a..z} is flagged so a key-search controller can drop the key.
// All memory-facing outputs are registered; memories have one wait state.
module rc4_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN          = 32,
  parameter int ABORT_ON_INVALID = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_flag,
  output logic              done_flag,
  output logic              fail_flag,
  output logic [BYTE_W-1:0] s_address,
  output logic [BYTE_W-1:0] s_data_in,
  input  logic [BYTE_W-1:0] s_data_out,
  output logic              s_wren,
  output logic [BYTE_W-1:0] rom_address,
  input  logic [BYTE_W-1:0] rom_data_out,
  output logic [BYTE_W-1:0] d_address,
  output logic [BYTE_W-1:0] d_data_in,
  output logic              d_wren
);

  localparam logic [BYTE_W-1:0] LAST_K = BYTE_W'(MSG_LEN - 1);
  localparam logic              ABORT  = (ABORT_ON_INVALID != 0);

  rc4_state_t state, state_nxt;

  // PRGA indices and the bytes fetched for the current message position.
  logic [BYTE_W-1:0] i, i_nxt;
  logic [BYTE_W-1:0] j, j_nxt;
  logic [BYTE_W-1:0] k, k_nxt;
  logic [BYTE_W-1:0] si, si_nxt;
  logic [BYTE_W-1:0] sj, sj_nxt;
  logic [BYTE_W-1:0] f, f_nxt;
  logic [BYTE_W-1:0] enc, enc_nxt;
  logic              invalid, invalid_nxt;

  // Next values of the registered outputs.
  logic              done_nxt;
  logic              fail_nxt;
  logic [BYTE_W-1:0] s_address_nxt;
  logic [BYTE_W-1:0] s_data_in_nxt;
  logic              s_wren_nxt;
  logic [BYTE_W-1:0] rom_address_nxt;
  logic [BYTE_W-1:0] d_address_nxt;
  logic [BYTE_W-1:0] d_data_in_nxt;
  logic              d_wren_nxt;

  logic last_byte;
  assign last_byte = (k == LAST_K);

  // State, datapath and output registers; reset clears everything so both
  // write enables are guaranteed low on the edge after reset is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      i           <= '0;
      j           <= '0;
      k           <= '0;
      si          <= '0;
      sj          <= '0;
      f           <= '0;
      enc         <= '0;
      invalid     <= 1'b0;
      done_flag   <= 1'b0;
      fail_flag   <= 1'b0;
      s_address   <= '0;
      s_data_in   <= '0;
      s_wren      <= 1'b0;
      rom_address <= '0;
      d_address   <= '0;
      d_data_in   <= '0;
      d_wren      <= 1'b0;
    end else begin
      state       <= state_nxt;
      i           <= i_nxt;
      j           <= j_nxt;
      k           <= k_nxt;
      si          <= si_nxt;
      sj          <= sj_nxt;
      f           <= f_nxt;
      enc         <= enc_nxt;
      invalid     <= invalid_nxt;
      done_flag   <= done_nxt;
      fail_flag   <= fail_nxt;
      s_address   <= s_address_nxt;
      s_data_in   <= s_data_in_nxt;
      s_wren      <= s_wren_nxt;
      rom_address <= rom_address_nxt;
      d_address   <= d_address_nxt;
      d_data_in   <= d_data_in_nxt;
      d_wren      <= d_wren_nxt;
    end
  end

  // Next-state and next-output logic. Outputs are computed one state early so
  // that they are stable, registered values for the whole of the target state;
  // write enables default low so they only pulse for a single write cycle.
  always_comb begin
    state_nxt       = state;
    i_nxt           = i;
    j_nxt           = j;
    k_nxt           = k;
    si_nxt          = si;
    sj_nxt          = sj;
    f_nxt           = f;
    enc_nxt         = enc;
    invalid_nxt     = invalid;
    done_nxt        = done_flag;
    fail_nxt        = fail_flag;
    s_address_nxt   = s_address;
    s_data_in_nxt   = s_data_in;
    s_wren_nxt      = 1'b0;
    rom_address_nxt = rom_address;
    d_address_nxt   = d_address;
    d_data_in_nxt   = d_data_in;
    d_wren_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        i_nxt       = '0;
        j_nxt       = '0;
        k_nxt       = '0;
        invalid_nxt = 1'b0;
        if (start_flag) begin
          state_nxt = INC_I;
        end
      end

      INC_I: begin
        i_nxt           = i + 8'd1;
        s_address_nxt   = i + 8'd1;
        rom_address_nxt = k;
        state_nxt       = WAIT_SI;
      end

      WAIT_SI: state_nxt = READ_SI;

      READ_SI: begin
        si_nxt    = s_data_out;
        enc_nxt   = rom_data_out;
        state_nxt = CALC_J;
      end

      CALC_J: begin
        j_nxt         = j + si;
        s_address_nxt = j + si;
        state_nxt     = WAIT_SJ;
      end

      WAIT_SJ: state_nxt = READ_SJ;

      // sj arrives now; set up the first swap write (S[i] <= S[j]) directly.
      READ_SJ: begin
        sj_nxt        = s_data_out;
        s_address_nxt = i;
        s_data_in_nxt = s_data_out;
        s_wren_nxt    = 1'b1;
        state_nxt     = WRITE_SI;
      end

      // Second swap write (S[j] <= old S[i]); when i == j both writes agree.
      WRITE_SI: begin
        s_address_nxt = j;
        s_data_in_nxt = si;
        s_wren_nxt    = 1'b1;
        state_nxt     = WRITE_SJ;
      end

      WRITE_SJ: state_nxt = SET_F;

      // Keystream index uses the pre-swap values; their sum equals the post-swap sum.
      SET_F: begin
        s_address_nxt = si + sj;
        state_nxt     = WAIT_F;
      end

      WAIT_F: state_nxt = READ_F;

      READ_F: begin
        f_nxt         = s_data_out;
        d_address_nxt = k;
        d_data_in_nxt = s_data_out ^ enc;
        d_wren_nxt    = 1'b1;
        state_nxt     = WRITE_D;
      end

      WRITE_D: begin
        if (!is_valid_char(f ^ enc)) begin
          invalid_nxt = 1'b1;
        end
        state_nxt = NEXT;
      end

      NEXT: begin
        if ((invalid && ABORT) || last_byte) begin
          done_nxt  = 1'b1;
          fail_nxt  = invalid;
          state_nxt = DONE;
        end else begin
          k_nxt     = k + 8'd1;
          state_nxt = INC_I;
        end
      end

      // Hold the result until the controller releases start.
      DONE: begin
        if (!start_flag) begin
          done_nxt  = 1'b0;
          fail_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rc4_decrypt.sv
// Bench for rc4_decrypt: three instances (2-byte, 32-byte aborting, 256-byte)
// with behavioural S/ROM memories. A software RC4 model fills a queue of
// expected plaintext writes, which are popped as the DUT writes them.
`timescale 1ns/1ps
module tb_rc4_decrypt;
  import rc4_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // instance a: MSG_LEN=2, no abort
  logic       start_a = 1'b0, done_a, fail_a, s_wren_a, d_wren_a;
  logic [7:0] s_addr_a, s_din_a, s_dout_a, rom_addr_a, rom_dout_a, d_addr_a, d_din_a;
  // instance b: MSG_LEN=32, abort on invalid
  logic       start_b = 1'b0, done_b, fail_b, s_wren_b, d_wren_b;
  logic [7:0] s_addr_b, s_din_b, s_dout_b, rom_addr_b, rom_dout_b, d_addr_b, d_din_b;
  // instance c: MSG_LEN=256, no abort
  logic       start_c = 1'b0, done_c, fail_c, s_wren_c, d_wren_c;
  logic [7:0] s_addr_c, s_din_c, s_dout_c, rom_addr_c, rom_dout_c, d_addr_c, d_din_c;

  logic [7:0] s_a [256], rom_a [256];
  logic [7:0] s_b [256], rom_b [256];
  logic [7:0] s_c [256], rom_c [256];
  logic [7:0] init_s [256], init_rom [256];
  logic [7:0] ms [256];
  logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0;

  wr_t  exp_q [$];
  logic exp_fail;

  rc4_decrypt #(.MSG_LEN(2), .ABORT_ON_INVALID(0)) u_a (
    .clk(clk), .reset(reset), .start_flag(start_a), .done_flag(done_a), .fail_flag(fail_a),
    .s_address(s_addr_a), .s_data_in(s_din_a), .s_data_out(s_dout_a), .s_wren(s_wren_a),
    .rom_address(rom_addr_a), .rom_data_out(rom_dout_a),
    .d_address(d_addr_a), .d_data_in(d_din_a), .d_wren(d_wren_a));

  rc4_decrypt #(.MSG_LEN(32), .ABORT_ON_INVALID(1)) u_b (
    .clk(clk), .reset(reset), .start_flag(start_b), .done_flag(done_b), .fail_flag(fail_b),
    .s_address(s_addr_b), .s_data_in(s_din_b), .s_data_out(s_dout_b), .s_wren(s_wren_b),
    .rom_address(rom_addr_b), .rom_data_out(rom_dout_b),
    .d_address(d_addr_b), .d_data_in(d_din_b), .d_wren(d_wren_b));

  rc4_decrypt #(.MSG_LEN(256), .ABORT_ON_INVALID(0)) u_c (
    .clk(clk), .reset(reset), .start_flag(start_c), .done_flag(done_c), .fail_flag(fail_c),
    .s_address(s_addr_c), .s_data_in(s_din_c), .s_data_out(s_dout_c), .s_wren(s_wren_c),
    .rom_address(rom_addr_c), .rom_data_out(rom_dout_c),
    .d_address(d_addr_c), .d_data_in(d_din_c), .d_wren(d_wren_c));

  // Synchronous memories with registered read data (one wait state).
  always @(posedge clk) begin
    if (load_a) begin
      s_a <= init_s; rom_a <= init_rom;
    end else if (s_wren_a) begin
      s_a[s_addr_a] <= s_din_a;
    end
    s_dout_a   <= s_a[s_addr_a];
    rom_dout_a <= rom_a[rom_addr_a];
    if (load_b) begin
      s_b <= init_s; rom_b <= init_rom;
    end else if (s_wren_b) begin
      s_b[s_addr_b] <= s_din_b;
    end
    s_dout_b   <= s_b[s_addr_b];
    rom_dout_b <= rom_b[rom_addr_b];
    if (load_c) begin
      s_c <= init_s; rom_c <= init_rom;
    end else if (s_wren_c) begin
      s_c[s_addr_c] <= s_din_c;
    end
    s_dout_c   <= s_c[s_addr_c];
    rom_dout_c <= rom_c[rom_addr_c];
  end

  int         sel = 0;
  logic       m_done, m_s_wren, m_d_wren;
  logic [7:0] m_d_addr, m_d_din;

  always_comb begin
    m_done = done_a; m_s_wren = s_wren_a; m_d_wren = d_wren_a;
    m_d_addr = d_addr_a; m_d_din = d_din_a;
    if (sel == 1) begin
      m_done = done_b; m_s_wren = s_wren_b; m_d_wren = d_wren_b;
      m_d_addr = d_addr_b; m_d_din = d_din_b;
    end else if (sel == 2) begin
      m_done = done_c; m_s_wren = s_wren_c; m_d_wren = d_wren_c;
      m_d_addr = d_addr_c; m_d_din = d_din_c;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_start(input int which, input logic v);
    case (which)
      0: start_a = v;
      1: start_b = v;
      default: start_c = v;
    endcase
  endtask

  task automatic load(input int which);
    case (which)
      0: load_a = 1'b1;
      1: load_b = 1'b1;
      default: load_c = 1'b1;
    endcase
    tick(1);
    load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
  endtask

  function automatic logic printable(input logic [7:0] p);
    return (p == 8'h20) || (p >= 8'h61 && p <= 8'h7a);
  endfunction

  // Reference RC4 PRGA over init_s/init_rom; leaves the final S in ms.
  task automatic model(input int len, input bit abort);
    logic [7:0] i, j, si, sj, p;
    wr_t w;
    exp_q.delete();
    exp_fail = 1'b0;
    ms = init_s;
    i = 8'd0;
    j = 8'd0;
    for (int n = 0; n < len; n++) begin
      i = i + 8'd1;
      si = ms[i];
      j = j + si;
      sj = ms[j];
      ms[i] = sj;
      ms[j] = si;
      p = ms[8'(si + sj)] ^ init_rom[n];
      w.addr = 8'(n);
      w.data = p;
      exp_q.push_back(w);
      if (!printable(p)) exp_fail = 1'b1;
      if (exp_fail && abort) break;
    end
  endtask

  // Start the selected instance and score every plaintext write until DONE.
  task automatic run(input int which, input int budget, output int cycles, output int nw);
    wr_t w;
    cycles = 0;
    nw = 0;
    sel = which;
    set_start(which, 1'b1);
    while (cycles < budget) begin
      tick(1);
      cycles++;
      check("wren_exclusive", {31'd0, m_s_wren & m_d_wren}, 32'd0);
      if (m_d_wren) begin
        nw++;
        if (exp_q.size() == 0) begin
          check("extra_d_write", {24'd0, m_d_addr}, 32'hffff_ffff);
        end else begin
          w = exp_q.pop_front();
          check("d_address", m_d_addr, w.addr);
          check("d_data_in", m_d_din, w.data);
        end
      end
      if (m_done) break;
    end
    check("done_reached", m_done, 1'b1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int         cyc, nw, nexp, diffs, r;
    wr_t        w;
    logic [7:0] pt, tmp;

    reset = 1'b1;
    tick(3);
    check("rst_done", done_a, 1'b0);
    check("rst_fail", fail_a, 1'b0);
    check("rst_s_wren", s_wren_a, 1'b0);
    check("rst_d_wren", d_wren_a, 1'b0);
    check("rst_s_address", s_addr_a, 8'h00);
    check("rst_d_data_in", d_din_a, 8'h00);
    check("rst_state", u_a.state, IDLE);
    reset = 1'b0;
    tick(1);

    // Identity S, zero ROM, 2 bytes: 0x02 then 0x05, s[2]/s[3] swapped.
    for (int n = 0; n < 256; n++) begin
      init_s[n] = 8'(n);
      init_rom[n] = 8'h00;
    end
    load(0);
    model(2, 1'b0);
    nexp = exp_q.size();
    run(0, 100, cyc, nw);
    check("t1_latency", cyc, 27);
    check("t1_nwrites", nw, nexp);
    check("t1_fail", fail_a, 1'b1);
    check("t1_s2", s_a[2], 8'h03);
    check("t1_s3", s_a[3], 8'h02);
    diffs = 0;
    for (int n = 0; n < 256; n++) if (s_a[n] !== ms[n]) diffs++;
    check("t1_s_rest", diffs, 0);

    // Holding start keeps DONE; releasing returns to IDLE with flags cleared.
    for (int n = 0; n < 10; n++) begin
      tick(1);
      check("hold_done", done_a, 1'b1);
    end
    check("hold_fail", fail_a, 1'b1);
    set_start(0, 1'b0);
    tick(1);
    check("drop_done", done_a, 1'b0);
    check("drop_fail", fail_a, 1'b0);
    check("drop_state", u_a.state, IDLE);

    // Printable plaintext 'aa'; i==j swap at byte 0 leaves s[1] alone.
    init_rom[0] = 8'h63;
    init_rom[1] = 8'h64;
    load(0);
    model(2, 1'b0);
    run(0, 100, cyc, nw);
    check("t2_latency", cyc, 27);
    check("t2_nwrites", nw, 2);
    check("t2_fail", fail_a, 1'b0);
    check("t2_s1", s_a[1], 8'h01);
    set_start(0, 1'b0);
    tick(2);

    // Second identical run after reload reproduces the first.
    init_rom[0] = 8'h00;
    init_rom[1] = 8'h00;
    load(0);
    model(2, 1'b0);
    run(0, 100, cyc, nw);
    check("rerun_latency", cyc, 27);
    check("rerun_nwrites", nw, 2);
    check("rerun_fail", fail_a, 1'b1);
    set_start(0, 1'b0);
    tick(2);

    // Abort on the first invalid byte: one write, then DONE with fail.
    load(1);
    model(32, 1'b1);
    run(1, 13 * 32 + 20, cyc, nw);
    check("abort_nwrites", nw, 1);
    check("abort_latency", cyc, 14);
    check("abort_fail", fail_b, 1'b1);
    check("abort_queue_empty", exp_q.size(), 0);
    set_start(1, 1'b0);
    tick(2);

    // Golden ROM: keystream XOR a random printable message.
    model(32, 1'b0);
    for (int n = 0; n < 32; n++) begin
      w = exp_q[n];
      r = $urandom_range(26, 0);
      pt = (r == 26) ? 8'h20 : (8'h61 + 8'(r));
      init_rom[n] = w.data ^ pt;
    end
    load(1);
    model(32, 1'b1);

    // Reset during WRITE_SI of byte 5.
    sel = 1;
    set_start(1, 1'b1);
    nw = 0;
    cyc = 0;
    while (cyc < 2000) begin
      tick(1);
      cyc++;
      if (d_wren_b) begin
        w = exp_q.pop_front();
        check("pre_rst_d_data_in", d_din_b, w.data);
        nw++;
      end
      if (nw == 5 && s_wren_b) break;
    end
    check("pre_rst_writes", nw, 5);
    check("pre_rst_in_write_si", u_b.state, WRITE_SI);
    set_start(1, 1'b0);
    reset = 1'b1;
    tick(1);
    check("mid_rst_s_wren", s_wren_b, 1'b0);
    check("mid_rst_d_wren", d_wren_b, 1'b0);
    check("mid_rst_s_address", s_addr_b, 8'h00);
    check("mid_rst_s_data_in", s_din_b, 8'h00);
    check("mid_rst_rom_address", rom_addr_b, 8'h00);
    check("mid_rst_d_address", d_addr_b, 8'h00);
    check("mid_rst_d_data_in", d_din_b, 8'h00);
    check("mid_rst_done", done_b, 1'b0);
    check("mid_rst_fail", fail_b, 1'b0);
    check("mid_rst_state", u_b.state, IDLE);
    reset = 1'b0;
    tick(1);
    load(1);
    model(32, 1'b1);
    run(1, 13 * 32 + 20, cyc, nw);
    check("golden_latency", cyc, 13 * 32 + 1);
    check("golden_nwrites", nw, 32);
    check("golden_fail", fail_b, 1'b0);
    set_start(1, 1'b0);
    tick(2);

    // 256-byte message with a random permutation S and random ROM.
    for (int n = 0; n < 256; n++) init_s[n] = 8'(n);
    for (int n = 255; n > 0; n--) begin
      r = $urandom_range(n, 0);
      tmp = init_s[n];
      init_s[n] = init_s[r];
      init_s[r] = tmp;
    end
    for (int n = 0; n < 256; n++) init_rom[n] = 8'($urandom);
    load(2);
    model(256, 1'b0);
    run(2, 13 * 256 + 50, cyc, nw);
    check("long_latency", cyc, 13 * 256 + 1);
    check("long_nwrites", nw, 256);
    check("long_fail", fail_c, exp_fail);
    check("long_i_wrapped", u_c.i, 8'h00);
    diffs = 0;
    for (int n = 0; n < 256; n++) if (s_c[n] !== ms[n]) diffs++;
    check("long_final_s", diffs, 0);
    set_start(2, 1'b0);
    tick(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
